// File: rtl/aes_state_pkg.sv
// Shared types for the AES state buffer: command opcodes, axis selectors
// and the controller FSM encoding.
package aes_state_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_SHIFT = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   localparam logic AXIS_ROW = 1'b0;
   localparam logic AXIS_COL = 1'b1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFTING
   } state_e;

endpackage

// File: rtl/aes_state_buf_row_rotator.sv
// Combinational rotation of one N-element row by amt_i positions.
// Element 0 sits in the MSBs; forward moves elements toward index 0.
module row_rotator #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N*W-1:0]   row_i,
   input  logic [IDX_W-1:0] amt_i,
   input  logic             inv_i,
   output logic [N*W-1:0]   row_o
);

   always_comb begin
      int unsigned amt;
      int unsigned src;
      row_o = '0;
      amt   = 32'(amt_i) % N;
      for (int unsigned j = 0; j < N; j++) begin
         src = inv_i ? ((j + N - amt) % N) : ((j + amt) % N);
         row_o[(N-j)*W-1 -: W] = row_i[(N-src)*W-1 -: W];
      end
   end

endmodule

// File: rtl/aes_state_buf.sv
// N x N matrix of W-bit cells with row/column read and write, a multi-cycle
// ShiftRows/InvShiftRows sweep and a one-cycle clear, behind a valid/ready port.
module aes_state_buf
   import aes_state_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_axis,
   input  logic [IDX_W-1:0] cmd_idx,
   input  logic             cmd_inv,
   input  logic [N*W-1:0]   cmd_data,
   output logic             rsp_valid,
   output logic [N*W-1:0]   rsp_data,
   output logic             busy
);

   logic [W-1:0]     cells_q [N][N];
   logic [W-1:0]     cells_d [N][N];
   state_e           state_q, state_d;
   logic [IDX_W-1:0] r_q, r_d;
   logic             inv_q, inv_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [N*W-1:0]   rsp_data_q, rsp_data_d;

   logic             accept;
   logic             idx_ok;
   logic [N*W-1:0]   rd_vec;
   logic [N*W-1:0]   shift_row;
   logic [N*W-1:0]   rot_row;

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_SHIFTING);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign accept    = cmd_valid && cmd_ready;
   // Only reachable as false when N is not a power of two.
   assign idx_ok    = ({1'b0, cmd_idx} < (IDX_W+1)'(N));

   always_comb begin
      rd_vec    = '0;
      shift_row = '0;
      for (int unsigned k = 0; k < N; k++) begin
         rd_vec[(N-k)*W-1 -: W]    = (cmd_axis == AXIS_ROW) ? cells_q[cmd_idx][k]
                                                            : cells_q[k][cmd_idx];
         shift_row[(N-k)*W-1 -: W] = cells_q[r_q][k];
      end
   end

   row_rotator #(.N(N), .W(W)) u_rot (
      .row_i (shift_row),
      .amt_i (r_q),
      .inv_i (inv_q),
      .row_o (rot_row)
   );

   always_comb begin
      cells_d     = cells_q;
      state_d     = state_q;
      r_d         = r_q;
      inv_d       = inv_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               unique case (op_e'(cmd_op))
                  OP_READ: begin
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = idx_ok ? rd_vec : '0;
                  end
                  OP_WRITE: begin
                     if (idx_ok) begin
                        for (int unsigned k = 0; k < N; k++) begin
                           if (cmd_axis == AXIS_ROW)
                              cells_d[cmd_idx][k] = cmd_data[(N-k)*W-1 -: W];
                           else
                              cells_d[k][cmd_idx] = cmd_data[(N-k)*W-1 -: W];
                        end
                     end
                  end
                  OP_SHIFT: begin
                     state_d = ST_SHIFTING;
                     inv_d   = cmd_inv;
                     r_d     = IDX_W'(1);
                  end
                  OP_CLEAR: cells_d = '{default: '0};
                  default: ;
               endcase
            end
         end
         ST_SHIFTING: begin
            for (int unsigned k = 0; k < N; k++)
               cells_d[r_q][k] = rot_row[(N-k)*W-1 -: W];
            r_d = r_q + IDX_W'(1);
            if (r_q == IDX_W'(N-1))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cells_q     <= '{default: '0};
         state_q     <= ST_IDLE;
         r_q         <= '0;
         inv_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         cells_q     <= cells_d;
         state_q     <= state_d;
         r_q         <= r_d;
         inv_q       <= inv_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

endmodule

// File: tb/tb_aes_state_buf.sv
// Table-driven bench for aes_state_buf with a response scoreboard and
// hand-written sequences for SHIFT stalls and reset mid-SHIFT.
module tb_aes_state_buf;
   import aes_state_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int DW = N * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic          cmd_axis;
   logic [1:0]    cmd_idx;
   logic          cmd_inv;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          busy;

   always #5 clk = ~clk;

   aes_state_buf #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_axis  (cmd_axis),
      .cmd_idx   (cmd_idx),
      .cmd_inv   (cmd_inv),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   typedef struct {
      logic [1:0]    op;
      logic          axis;
      logic [1:0]    idx;
      logic          inv;
      logic [DW-1:0] data;
      logic [DW-1:0] exp;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   vec_t          tbl[$];
   exp_t          sb[$];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   logic [DW-1:0] last_rsp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", DW'(rsp_valid), '0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_latency", DW'(cyc), DW'(e.due));
            end
            last_rsp = rsp_data;
         end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               check("rsp_missing", DW'(rsp_valid), DW'(1));
               void'(sb.pop_front());
            end
            check("rsp_hold", rsp_data, last_rsp);
         end
      end
   end

   function automatic void add(input logic [1:0] op, input logic axis, input logic [1:0] idx,
                               input logic inv, input logic [DW-1:0] data, input logic [DW-1:0] exp);
      vec_t v;
      v.op = op; v.axis = axis; v.idx = idx; v.inv = inv; v.data = data; v.exp = exp;
      tbl.push_back(v);
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic axis, input logic [1:0] idx,
                        input logic inv, input logic [DW-1:0] data, input logic [DW-1:0] exp,
                        output int stalls, output int busy_err);
      exp_t e;
      stalls   = 0;
      busy_err = 0;
      cmd_valid = 1'b1;
      cmd_op = op; cmd_axis = axis; cmd_idx = idx; cmd_inv = inv; cmd_data = data;
      while (!cmd_ready && stalls <= 20) begin
         if (busy !== 1'b1) busy_err++;
         @(posedge clk);
         @(negedge clk);
         stalls++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", DW'(cmd_ready), DW'(1));
         cmd_valid = 1'b0;
         return;
      end
      if (busy !== 1'b0) busy_err++;
      if (op == OP_READ) begin
         e.data = exp;
         e.due  = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int stalls;
      int berr;

      cmd_valid = 1'b0; cmd_op = '0; cmd_axis = 1'b0; cmd_idx = '0; cmd_inv = 1'b0; cmd_data = '0;
      rst = 1'b1;
      #3;
      check("reset_cmd_ready", DW'(cmd_ready), DW'(1));
      check("reset_busy",      DW'(busy),      '0);
      check("reset_rsp_valid", DW'(rsp_valid), '0);
      check("reset_rsp_data",  rsp_data,       '0);
      #9 rst = 1'b0;
      @(negedge clk);

      add(OP_READ,  AXIS_ROW, 2, 0, '0, 32'h00000000);
      add(OP_WRITE, AXIS_ROW, 0, 0, 32'h00010203, '0);
      add(OP_WRITE, AXIS_ROW, 1, 0, 32'h10111213, '0);
      add(OP_WRITE, AXIS_ROW, 2, 0, 32'h20212223, '0);
      add(OP_WRITE, AXIS_ROW, 3, 0, 32'h30313233, '0);
      add(OP_READ,  AXIS_COL, 0, 0, '0, 32'h00102030);
      add(OP_READ,  AXIS_COL, 3, 0, '0, 32'h03132333);
      add(OP_SHIFT, AXIS_ROW, 0, 0, '0, '0);
      add(OP_READ,  AXIS_ROW, 0, 0, '0, 32'h00010203);
      add(OP_READ,  AXIS_ROW, 1, 0, '0, 32'h11121310);
      add(OP_READ,  AXIS_ROW, 2, 0, '0, 32'h22232021);
      add(OP_READ,  AXIS_ROW, 3, 0, '0, 32'h33303132);
      add(OP_READ,  AXIS_COL, 0, 0, '0, 32'h00112233);
      add(OP_SHIFT, AXIS_ROW, 0, 1, '0, '0);
      add(OP_READ,  AXIS_ROW, 0, 0, '0, 32'h00010203);
      add(OP_READ,  AXIS_ROW, 1, 0, '0, 32'h10111213);
      add(OP_READ,  AXIS_ROW, 2, 0, '0, 32'h20212223);
      add(OP_READ,  AXIS_ROW, 3, 0, '0, 32'h30313233);
      add(OP_WRITE, AXIS_COL, 1, 0, 32'hAABBCCDD, '0);
      add(OP_READ,  AXIS_ROW, 1, 0, '0, 32'h10BB1213);
      add(OP_READ,  AXIS_COL, 1, 0, '0, 32'hAABBCCDD);
      add(OP_CLEAR, AXIS_ROW, 0, 0, '0, '0);
      add(OP_READ,  AXIS_ROW, 0, 0, '0, 32'h00000000);
      add(OP_READ,  AXIS_COL, 2, 0, '0, 32'h00000000);

      for (int i = 0; i < tbl.size(); i++) begin
         issue(tbl[i].op, tbl[i].axis, tbl[i].idx, tbl[i].inv, tbl[i].data, tbl[i].exp, stalls, berr);
         if (i > 0 && tbl[i-1].op == OP_SHIFT) begin
            check("shift_stall_cycles", DW'(stalls), DW'(N-1));
            check("shift_busy_track",   DW'(berr),   '0);
         end else begin
            check("no_stall", DW'(stalls), '0);
         end
      end

      // Reload, start a SHIFT, then hit reset during its second cycle.
      issue(OP_WRITE, AXIS_ROW, 0, 0, 32'h00010203, '0, stalls, berr);
      issue(OP_WRITE, AXIS_ROW, 1, 0, 32'h10111213, '0, stalls, berr);
      issue(OP_WRITE, AXIS_ROW, 2, 0, 32'h20212223, '0, stalls, berr);
      issue(OP_WRITE, AXIS_ROW, 3, 0, 32'h30313233, '0, stalls, berr);
      issue(OP_READ,  AXIS_ROW, 3, 0, '0, 32'h30313233, stalls, berr);
      issue(OP_SHIFT, AXIS_ROW, 0, 0, '0, '0, stalls, berr);
      check("shift_busy_high",  DW'(busy),      DW'(1));
      check("shift_ready_low",  DW'(cmd_ready), '0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midshift_rst_busy",      DW'(busy),      '0);
      check("midshift_rst_cmd_ready", DW'(cmd_ready), DW'(1));
      check("midshift_rst_rsp_valid", DW'(rsp_valid), '0);
      check("midshift_rst_rsp_data",  rsp_data,       '0);
      last_rsp = '0;
      #1 rst = 1'b0;
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
         issue(OP_READ, AXIS_ROW, 2'(r), 0, '0, '0, stalls, berr);
         check("post_rst_no_stall", DW'(stalls), '0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", DW'(sb.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_state_buf.md
Name: aes_state_buf

Overview:
Clocked, parametrised successor of the AES state matrix. Holds an N x N matrix of W-bit cells and supports row or column write and read through a single command port with a valid/ready handshake. Also provides a multi-cycle ShiftRows / InvShiftRows operation and a one-cycle clear. Sits between the round datapath (SubBytes/MixColumns) and the round controller. The controller issues commands and the datapath consumes read responses.

Parameters:
N, 4, matrix dimension (rows = columns); N >= 2
W, 8, cell width in bits
IDX_W, $clog2(N), localparam; index width

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  operation: READ=0, WRITE=1, SHIFT=2, CLEAR=3
cmd_axis  in  1  0 = row, 1 = column (READ/WRITE only)
cmd_idx  in  IDX_W  row or column index (READ/WRITE only)
cmd_inv  in  1  SHIFT only: 0 = forward (rotate left), 1 = inverse (rotate right)
cmd_data  in  N*W  WRITE payload
rsp_valid  out  1  read response valid (single-cycle pulse)
rsp_data  out  N*W  read response payload
busy  out  1  SHIFT in progress

Behaviour:
- Reset: asynchronous, active-high. All cells are 0, rsp_valid=0, rsp_data=0, busy=0, FSM=IDLE, so cmd_ready=1.
- Packing, identical for rows and columns: element 0 (column 0 of a row, or row 0 of a column) is in the MSBs, bits [N*W-1 -: W]. Element k is in bits [(N-k)*W-1 -: W].
- Accept: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready = (FSM == IDLE) and depends only on state. It never depends on cmd_valid.
- FSM states: IDLE and SHIFTING.
- WRITE: the addressed row or column is updated at the accepting edge. The FSM stays IDLE. Back-to-back writes are allowed every cycle.
- READ: rsp_data is registered at the accepting edge from the pre-edge matrix. rsp_valid=1 for exactly the following cycle. Latency is 1. There is no response backpressure.
  - Back-to-back reads produce back-to-back responses.
  - A READ in the cycle after a WRITE returns the written data.
  - rsp_data holds its last value when rsp_valid=0.
- CLEAR: all cells are set to 0 at the accepting edge. The FSM stays IDLE.
- SHIFT: on accept, go to SHIFTING and set busy=1 and cmd_ready=0. Latch cmd_inv and set row counter r=1.
  - Each SHIFTING cycle rotates row r by r positions (left if forward, right if inverse), then increments r.
  - After row N-1 is done, return to IDLE.
  - Row 0 is never modified.
  - busy/cmd_ready are held for exactly N-1 cycles; a new command can be accepted on the Nth cycle after the SHIFT accept.
  - Forward followed by inverse restores the original matrix.
- Out-of-range cmd_idx (only possible when N is not a power of 2): WRITE is ignored, READ returns 0 with rsp_valid still pulsed.
- cmd_op/axis/idx/data/inv are don't-care when cmd_valid=0.
- Reset mid-SHIFT: aborts immediately. The matrix is zeroed and the FSM returns to IDLE.
- No X is ever driven on outputs. This replaces the earlier don't-care output behaviour.

Decomposition:
- Package aes_state_pkg holds:
  - the op enum (OP_READ, OP_WRITE, OP_SHIFT, OP_CLEAR)
  - axis constants AXIS_ROW=0 and AXIS_COL=1
  - the FSM state enum (ST_IDLE, ST_SHIFTING)
- One combinational sub-module, row_rotator (params N, W). Inputs are a row vector, a rotate amount and a direction; the output is the rotated row. It is reused by the SHIFT path and is unit-testable alone.

Test Plan:
- Reset, then read row 2 -> rsp_valid one cycle later, rsp_data=32'h00000000; cmd_ready=1 throughout.
- Write rows 0..3 = 00010203, 10111213, 20212223, 30313233, then read column 0 -> 32'h00102030; read column 3 -> 32'h03132333; each response arrives exactly 1 cycle after its accept.
- Same load, then SHIFT with cmd_inv=0 -> cmd_ready=0 and busy=1 for exactly 3 cycles. Then rows read 00010203, 11121310, 22232021, 33303132, and column 0 = 32'h00112233.
- SHIFT with cmd_inv=0 then SHIFT with cmd_inv=1 -> matrix equals the original load. A READ held valid during SHIFTING is accepted only after busy falls.
- Write column 1 = AABBCCDD with a READ of row 1 in the next cycle -> row 1 = 10BB1213. CLEAR, then read row 0 -> 00000000.
- Assert rst during the 2nd SHIFTING cycle -> all outputs return to reset values asynchronously; the next READ of any row returns 0.
